d_mem_wait_slave: RTL and testbench
===================================

Name: d_mem_wait_slave

Overview:
- Data-memory responder for the monocycle core's load/store interface (Address, WriteData, MemRead, MemWrite, ReadData), with configurable access latency.
- Owns a word-addressed RAM and runs a small FSM.
- Drives a combinational Stall back to the core so the core holds PC and its request until the access completes.
- Enables the core to run against slow memory or memory-mapped peripherals without changing d_mem-facing semantics.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; valid word index range 0..DEPTH_WORDS-1.
- LATENCY, 2, cycles from request sampling edge to Ready cycle; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from control unit.
- MemWrite  in  1  store request from control unit.
- Address  in  32  byte address from ALU result.
- WriteData  in  32  store data (regfile read data 2).
- ReadData  out  32  registered load data.
- Ready  out  1  registered; one-cycle pulse marking access completion.
- Stall  out  1  combinational; core must not advance PC while 1.
- Error  out  1  registered; valid only in the Ready cycle.

Behaviour:
- Reset: on a rising edge with reset=1, state=IDLE, wait counter=0, ReadData=0, Ready=0, Error=0. Any captured pending write is discarded. RAM contents are not cleared.
- FSM states:
  - IDLE: if (MemRead|MemWrite) at the edge, capture Address, WriteData and op; load counter with LATENCY-1. If LATENCY=1, go to DONE; otherwise go to WAIT.
  - WAIT: decrement counter each edge; when counter=1, go to DONE on that edge.
  - DONE: Ready=1 for exactly this cycle; request inputs are ignored; unconditionally return to IDLE.
- Commit edge (the edge entering DONE):
  - A valid write updates RAM[word index].
  - A valid read loads ReadData from RAM.
  - Error is set if the access is invalid, cleared otherwise.
- Latency: Ready rises exactly LATENCY cycles after the sampling edge. Back-to-back accesses cost LATENCY+1 cycles each, including the IDLE sampling cycle.
- Stall = (MemRead|MemWrite) & (state != DONE). Stall is 0 whenever no request is present.
- Word index = Address[31:2]. Address[1:0] is used only for the alignment check.
- Invalid accesses (all give Error=1 in DONE, no RAM write, ReadData unchanged):
  - Address[1:0] != 0.
  - Address[31:2] >= DEPTH_WORDS.
  - MemRead and MemWrite both 1.
- Inputs changing during WAIT are ignored; captured values are used.
- ReadData holds its value until the next valid read commits. Writes do not alter ReadData.
- A read captured in the cycle after a write to the same address returns the new data (the write commits first).
- Ready and Error are 0 in IDLE and WAIT.
- Reset in WAIT or DONE: next state IDLE, Ready=0 the following cycle, and no commit occurs even if the commit edge coincides with reset.

Test Plan:
- Reset, then MemWrite=1, Address=0x10, WriteData=0xDEADBEEF, LATENCY=2 → Stall=1 for 2 cycles; Ready pulses on the 3rd cycle with Stall=0 and Error=0; RAM[4]=0xDEADBEEF.
- Next, MemRead=1, Address=0x10 → ReadData=0xDEADBEEF in the Ready cycle, exactly 2 cycles after sampling; ReadData persists after the request drops.
- MemRead=1, Address=0x13 → Ready with Error=1; ReadData keeps 0xDEADBEEF.
- MemWrite=1, Address=0x400 with DEPTH_WORDS=256 → Error=1. A following read of Address=0x0 returns the prior RAM[0] value unchanged.
- Start a write of 0x12345678 to 0x20, assert reset during WAIT → Ready never pulses; ReadData=0. A later read of 0x20 does not return 0x12345678.
- LATENCY=1: MemRead and MemWrite both 1 → Ready with Error=1 one cycle after sampling, no RAM change. Then a normal read of 0x10 gives Ready 1 cycle after sampling, with Stall high for exactly 1 cycle.

Source files
------------

// File: rtl/d_mem_wait_slave.sv
// Word-addressed data memory with a configurable access latency.
// The core holds its request under Stall; the access commits on the edge entering DONE.
module d_mem_wait_slave #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Stall,
   output logic        Error,
   output logic [1:0]  dbg_state
);

   // Handshake: a request (MemRead|MemWrite) is sampled on an IDLE edge; the core keeps
   // it asserted while Stall=1. Ready pulses for one cycle (DONE) with ReadData/Error valid,
   // Stall drops in that cycle, and request inputs are ignored until the FSM is back in IDLE.

   localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic            c_rd, c_wr, c_valid, commit;
   logic [31:0]     c_addr, c_wdata;
   logic [IDXW-1:0] c_idx;

   // With LATENCY=1 the commit edge is the sampling edge, so it sees the live inputs.
   always_comb begin
      c_rd    = (state_q == S_IDLE) ? MemRead   : rd_q;
      c_wr    = (state_q == S_IDLE) ? MemWrite  : wr_q;
      c_addr  = (state_q == S_IDLE) ? Address   : addr_q;
      c_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
      c_idx   = c_addr[IDXW+1:2];
      c_valid = (c_addr[1:0] == 2'b00) && ({2'b00, c_addr[31:2]} < DEPTH_L) && !(c_rd && c_wr);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      error_d = 1'b0;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MemRead || MemWrite) begin
               addr_d  = Address;
               wdata_d = WriteData;
               rd_d    = MemRead;
               wr_d    = MemWrite;
               cnt_d   = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d = S_DONE;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (commit) begin
         ready_d = 1'b1;
         error_d = !c_valid;
         if (c_valid && c_rd) begin
            rdata_d = mem[c_idx];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
      end
   end

   // RAM is never cleared; reset only suppresses a coinciding commit.
   always_ff @(posedge clock) begin
      if (!reset && commit && c_valid && c_wr) begin
         mem[c_idx] <= c_wdata;
      end
   end

   assign ReadData  = rdata_q;
   assign Ready     = ready_q;
   assign Error     = error_q;
   assign Stall     = (MemRead || MemWrite) && (state_q != S_DONE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_d_mem_wait_slave.sv
// Directed bench: a LATENCY=2 instance driven from a vector table plus hand sequences,
// and a LATENCY=1 instance for the single-cycle corner cases.
module tb_d_mem_wait_slave;

   logic        clock;
   logic        rst, rst1;
   logic        MemRead, MemWrite, rd1, wr1;
   logic [31:0] Address, WriteData, addr1, wdata1;
   logic [31:0] ReadData, rdata1;
   logic        Ready, Stall, Error, ready1, stall1, error1;
   logic [1:0]  dbg_state, dbg1;

   int total = 0;
   int bad   = 0;

   d_mem_wait_slave #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clock(clock), .reset(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
      .Ready(Ready), .Stall(Stall), .Error(Error), .dbg_state(dbg_state)
   );

   d_mem_wait_slave #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clock(clock), .reset(rst1), .MemRead(rd1), .MemWrite(wr1),
      .Address(addr1), .WriteData(wdata1), .ReadData(rdata1),
      .Ready(ready1), .Stall(stall1), .Error(error1), .dbg_state(dbg1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full access on the LATENCY=2 instance: sample cycle, one WAIT cycle, Ready cycle, idle cycle.
   task automatic access2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd, input string tag);
      MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
      #1;
      chk({tag, "_stall_sample"}, 32'(Stall), 32'd1);
      chk({tag, "_ready_sample"}, 32'(Ready), 32'd0);
      tick();
      chk({tag, "_state_wait"}, 32'(dbg_state), 32'd1);
      chk({tag, "_stall_wait"}, 32'(Stall), 32'd1);
      chk({tag, "_ready_wait"}, 32'(Ready), 32'd0);
      chk({tag, "_error_wait"}, 32'(Error), 32'd0);
      tick();
      chk({tag, "_ready_done"}, 32'(Ready), 32'd1);
      chk({tag, "_error_done"}, 32'(Error), 32'(e_err));
      chk({tag, "_stall_done"}, 32'(Stall), 32'd0);
      chk({tag, "_rdata_done"}, ReadData, e_rd);
      MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
      tick();
      chk({tag, "_ready_after"}, 32'(Ready), 32'd0);
      chk({tag, "_error_after"}, 32'(Error), 32'd0);
      chk({tag, "_rdata_hold"}, ReadData, e_rd);
   endtask

   task automatic access1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd, input string tag);
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
      #1;
      chk({tag, "_stall_sample"}, 32'(stall1), 32'd1);
      chk({tag, "_ready_sample"}, 32'(ready1), 32'd0);
      tick();
      chk({tag, "_ready_done"}, 32'(ready1), 32'd1);
      chk({tag, "_error_done"}, 32'(error1), 32'(e_err));
      chk({tag, "_stall_done"}, 32'(stall1), 32'd0);
      chk({tag, "_rdata_done"}, rdata1, e_rd);
      rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
      tick();
      chk({tag, "_ready_after"}, 32'(ready1), 32'd0);
      chk({tag, "_rdata_hold"}, rdata1, e_rd);
   endtask

   initial begin
      //           rd    wr    addr           wdata          err   rdata
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_A5A5, 1'b0, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 1'b1, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_A5A5};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h1111_2222, 1'b0, 32'h0000_A5A5};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'h1111_2222};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_03FE, 32'h0000_0000, 1'b1, 32'h1111_2222};
      vecs[9]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'h1111_2222};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
      vecs[13] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};

      rst = 1'b1; rst1 = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
      tick();
      tick();
      chk("reset_ready", 32'(Ready), 32'd0);
      chk("reset_error", 32'(Error), 32'd0);
      chk("reset_rdata", ReadData, 32'd0);
      chk("reset_stall", 32'(Stall), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0; rst1 = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) begin
         access2(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      end

      // Back-to-back write then read of the same word; inputs ignored in DONE and WAIT.
      MemWrite = 1'b1; Address = 32'h20; WriteData = 32'h0000_0055;
      #1;
      chk("b2b_stall_sample", 32'(Stall), 32'd1);
      tick();
      chk("b2b_ready_wait", 32'(Ready), 32'd0);
      tick();
      chk("b2b_wr_ready", 32'(Ready), 32'd1);
      chk("b2b_wr_error", 32'(Error), 32'd0);
      MemWrite = 1'b0; MemRead = 1'b1; Address = 32'h20; WriteData = 32'd0;
      #1;
      chk("b2b_stall_done_with_req", 32'(Stall), 32'd0);
      tick();
      chk("b2b_rd_ready_idle", 32'(Ready), 32'd0);
      chk("b2b_rd_stall_idle", 32'(Stall), 32'd1);
      chk("b2b_rd_state_idle", 32'(dbg_state), 32'd0);
      tick();
      Address = 32'h13; MemWrite = 1'b1; WriteData = 32'hFFFF_FFFF;
      #1;
      chk("b2b_rd_stall_wait", 32'(Stall), 32'd1);
      chk("b2b_rd_ready_wait", 32'(Ready), 32'd0);
      tick();
      chk("b2b_rd_ready", 32'(Ready), 32'd1);
      chk("b2b_rd_error", 32'(Error), 32'd0);
      chk("b2b_rd_data", ReadData, 32'h0000_0055);
      MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
      tick();
      chk("b2b_ready_after", 32'(Ready), 32'd0);

      // Reset lands on the commit edge of a pending write.
      MemWrite = 1'b1; Address = 32'h20; WriteData = 32'h1234_5678;
      tick();
      chk("rstwait_state_wait", 32'(dbg_state), 32'd1);
      rst = 1'b1;
      tick();
      chk("rstwait_ready", 32'(Ready), 32'd0);
      chk("rstwait_rdata", ReadData, 32'd0);
      chk("rstwait_state", 32'(dbg_state), 32'd0);
      rst = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rstwait_no_ready%0d", i), 32'(Ready), 32'd0);
      end
      access2(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'h0000_0055, "rstwait_readback");

      // LATENCY=1 instance.
      access1(1'b0, 1'b1, 32'h10, 32'h0000_0077, 1'b0, 32'd0, "l1_write");
      access1(1'b1, 1'b1, 32'h10, 32'h0000_0099, 1'b1, 32'd0, "l1_both");
      access1(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'h0000_0077, "l1_read");
      access1(1'b1, 1'b0, 32'h11, 32'd0, 1'b1, 32'h0000_0077, "l1_misalign");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
